// File: rtl/divider.sv
// divider: multi-cycle 32-bit radix-2 restoring integer divider for DIV/DIVU
// in the EX stage. One quotient bit is produced per cycle.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   start      EX holds a DIV/DIVU, operands valid
//   signed_div 1 = DIV (two's complement), 0 = DIVU; sampled with start
//   cancel     EX flush; aborts any operation in flight (priority over start)
//   a, b       dividend / divisor, sampled on accept
//   stall_div  pipeline must hold F/D/E (combinational)
//   ready      one-cycle pulse, results valid
//   quotient   to LO
//   remainder  to HI
//
// Optional build macro DIV_ZERO_FAST_EN: a zero divisor goes IDLE->DONE
// directly on accept, with the same result values as the full-length path.
module divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_div,
  input  logic             cancel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             stall_div,
  output logic             ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dq;
  logic [WIDTH-1:0] divisor;
  logic             neg_q;
  logic             neg_r;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] dq_next;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic             b_zero;

  // Operand magnitudes for the accept cycle.
  always_comb begin
    mag_a  = (signed_div && a[WIDTH-1]) ? -a : a;
    mag_b  = (signed_div && b[WIDTH-1]) ? -b : b;
    b_zero = (b == '0);
  end

  // One restoring step: shift {rem,dq} left, trial-subtract the divisor.
  always_comb begin
    shifted = {rem, dq[WIDTH-1]};
    trial   = shifted - {1'b0, divisor};
    if (!trial[WIDTH]) begin
      rem_next = trial[WIDTH-1:0];
      dq_next  = {dq[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = shifted[WIDTH-1:0];
      dq_next  = {dq[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    stall_div = (((state == IDLE) && start) || (state == BUSY)) && !cancel;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      count     <= '0;
      rem       <= '0;
      dq        <= '0;
      divisor   <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      ready     <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      ready <= 1'b0;
      if (cancel) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              count   <= '0;
              rem     <= '0;
              dq      <= mag_a;
              divisor <= mag_b;
              // A zero divisor yields all-ones quotient with no sign fix-up;
              // the remainder fix-up (-|a| when a<0) already restores a.
              neg_q   <= signed_div && (a[WIDTH-1] ^ b[WIDTH-1]) && !b_zero;
              neg_r   <= signed_div && a[WIDTH-1];
`ifdef DIV_ZERO_FAST_EN
              if (b_zero) begin
                state     <= DONE;
                ready     <= 1'b1;
                quotient  <= '1;
                remainder <= a;
              end else begin
                state <= BUSY;
              end
`else
              state <= BUSY;
`endif
            end
          end
          BUSY: begin
            rem   <= rem_next;
            dq    <= dq_next;
            count <= count + 1'b1;
            if (count == LAST) begin
              state     <= DONE;
              ready     <= 1'b1;
              quotient  <= neg_q ? -dq_next : dq_next;
              remainder <= neg_r ? -rem_next : rem_next;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_divider.sv
// tb_divider: self-checking bench for divider. Randomized and directed
// operations are checked against a plain-arithmetic reference model.
module tb_divider;

  logic        clk;
  logic        rst;
  logic        start;
  logic        signed_div;
  logic        cancel;
  logic [31:0] a;
  logic [31:0] b;
  logic        stall_div;
  logic        ready;
  logic [31:0] quotient;
  logic [31:0] remainder;

  int n_cmp;
  int n_fail;
  logic [31:0] last_q;
  logic [31:0] last_r;

`ifdef DIV_ZERO_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  divider #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_div (signed_div),
    .cancel     (cancel),
    .a          (a),
    .b          (b),
    .stall_div  (stall_div),
    .ready      (ready),
    .quotient   (quotient),
    .remainder  (remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: MIPS DIV/DIVU results from ordinary arithmetic.
  function automatic void ref_div(input logic [31:0] x, input logic [31:0] y,
                                  input logic sg, output logic [31:0] q,
                                  output logic [31:0] r);
    int sx;
    int sy;
    sx = x;
    sy = y;
    if (y == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = x;
    end else if (!sg) begin
      q = x / y;
      r = x % y;
    end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      q = sx / sy;
      r = sx % sy;
    end
  endfunction

  // Runs one operation starting at the next negedge (cycle 0). Returns in
  // the ready cycle (or after the cycle budget expires).
  task automatic run_div(input logic [31:0] x, input logic [31:0] y,
                         input logic sg, input string name);
    logic [31:0] eq;
    logic [31:0] er;
    int exp_cyc;
    int got_cyc;
    bit stall_ok;
    ref_div(x, y, sg, eq, er);
    exp_cyc = (FAST && y == 32'd0) ? 1 : 33;
    @(negedge clk);
    a = x; b = y; signed_div = sg; start = 1'b1; cancel = 1'b0;
    #1;
    n_cmp++;
    if (stall_div !== 1'b1 || ready !== 1'b0 || quotient !== last_q || remainder !== last_r) begin
      n_fail++;
      $display("FAIL %s accept: stall=%b ready=%b q=%h r=%h, want stall=1 ready=0 q=%h r=%h",
               name, stall_div, ready, quotient, remainder, last_q, last_r);
    end
    got_cyc  = -1;
    stall_ok = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start = 1'b0;
      a = $urandom; b = $urandom;
      #1;
      if (stall_div !== ((c < exp_cyc) ? 1'b1 : 1'b0)) stall_ok = 1'b0;
      if (ready === 1'b1) begin
        got_cyc = c;
        break;
      end
    end
    n_cmp++;
    if (got_cyc != exp_cyc) begin
      n_fail++;
      $display("FAIL %s ready_cycle: got %0d, want %0d", name, got_cyc, exp_cyc);
    end
    n_cmp++;
    if (!stall_ok) begin
      n_fail++;
      $display("FAIL %s stall_profile: stall_div wrong before cycle %0d", name, exp_cyc);
    end
    n_cmp++;
    if (quotient !== eq || remainder !== er) begin
      n_fail++;
      $display("FAIL %s result: q=%h r=%h, want q=%h r=%h", name, quotient, remainder, eq, er);
    end
    last_q = eq;
    last_r = er;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; cancel = 1'b0; signed_div = 1'b0; a = '0; b = '0;
    last_q = '0; last_r = '0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if (stall_div !== 1'b0 || ready !== 1'b0 || quotient !== 32'd0 || remainder !== 32'd0) begin
      n_fail++;
      $display("FAIL reset: stall=%b ready=%b q=%h r=%h, want all 0",
               stall_div, ready, quotient, remainder);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_directed();
    run_div(32'd100, 32'd7, 1'b0, "u100_7");
    run_div(-32'sd7, 32'd2, 1'b1, "s-7_2");
    run_div(32'd7, -32'sd2, 1'b1, "s7_-2");
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "s_overflow");
    run_div(32'hFFFF_FFFF, 32'd1, 1'b0, "u_max_1");
    run_div(32'hFFFF_FFF0, 32'd0, 1'b1, "s_divzero");
    run_div(32'h8000_0000, 32'd0, 1'b1, "s_divzero_min");
    run_div(32'h1234_5678, 32'd0, 1'b0, "u_divzero");
    run_div(32'd5, 32'd9, 1'b0, "u_small");
  endtask

  task automatic test_random();
    logic [31:0] x;
    logic [31:0] y;
    for (int i = 0; i < 24; i++) begin
      x = $urandom;
      case ($urandom_range(3))
        0:       y = $urandom;
        1:       y = $urandom_range(15);
        2:       y = -($urandom_range(15));
        default: y = $urandom >> $urandom_range(31);
      endcase
      run_div(x, y, 1'($urandom_range(1)), "random");
    end
  endtask

  task automatic test_done_start();
    run_div(32'd1000, 32'd10, 1'b0, "pre_done_start");
    // Still in the DONE cycle: a start here belongs to the departing instruction.
    start = 1'b1;
    #1;
    n_cmp++;
    if (stall_div !== 1'b0) begin
      n_fail++;
      $display("FAIL done_start stall: got %b, want 0", stall_div);
    end
    @(negedge clk);
    start = 1'b0;
    #1;
    n_cmp++;
    if (stall_div !== 1'b0 || ready !== 1'b0) begin
      n_fail++;
      $display("FAIL done_start ignored: stall=%b ready=%b, want 0 0", stall_div, ready);
    end
  endtask

  task automatic test_cancel();
    bit ready_seen;
    @(negedge clk);
    a = 32'd999; b = 32'd3; signed_div = 1'b0; start = 1'b1; cancel = 1'b0;
    ready_seen = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (ready !== 1'b0) ready_seen = 1'b1;
    end
    @(negedge clk);
    cancel = 1'b1;
    #1;
    n_cmp++;
    if (stall_div !== 1'b0 || ready !== 1'b0 || ready_seen) begin
      n_fail++;
      $display("FAIL cancel cycle10: stall=%b ready=%b early_ready=%b, want 0 0 0",
               stall_div, ready, ready_seen);
    end
    n_cmp++;
    if (quotient !== last_q || remainder !== last_r) begin
      n_fail++;
      $display("FAIL cancel held: q=%h r=%h, want q=%h r=%h", quotient, remainder, last_q, last_r);
    end
    run_div(32'd77, 32'd5, 1'b0, "after_cancel");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    a = 32'hDEAD_BEEF; b = 32'd13; signed_div = 1'b0; start = 1'b1; cancel = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (stall_div !== 1'b0 || ready !== 1'b0 || quotient !== 32'd0 || remainder !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_mid: stall=%b ready=%b q=%h r=%h, want all 0",
               stall_div, ready, quotient, remainder);
    end
    last_q = '0;
    last_r = '0;
    @(negedge clk);
    rst = 1'b1;
    run_div(32'd50, 32'd5, 1'b0, "after_reset");
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_directed();
    test_random();
    test_done_start();
    test_cancel();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
